// File: rtl/strip_write_scheduler.sv
// Routes a frame of pixels into STRIP_COUNT strip RAMs in strip-major order, one registered write per accept.
// Latency: 1 cycle from accept to write strobe. Backpressure: ready only while loading, forced low on frame_start_i.
module strip_write_scheduler #(
  parameter int LED_COUNT   = 240,
  parameter int STRIP_COUNT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   frame_start_i,
  input  logic                   pixel_valid_i,
  input  logic [7:0]             pixel_r_i,
  input  logic [7:0]             pixel_g_i,
  input  logic [7:0]             pixel_b_i,
  output logic                   pixel_ready_o,
  output logic [7:0]             pixel_r_o,
  output logic [7:0]             pixel_g_o,
  output logic [7:0]             pixel_b_o,
  output logic [8:0]             led_address_o,
  output logic [STRIP_COUNT-1:0] strip_we_o,
  output logic                   frame_busy_o,
  output logic                   frame_done_o,
  output logic                   abort_o,
  input  logic                   clear_abort_i
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [8:0] LAST_ADDR  = 9'(LED_COUNT - 1);
  localparam logic [2:0] LAST_STRIP = 3'(STRIP_COUNT - 1);

  state_t                 state;
  logic [8:0]             addr;
  logic [2:0]             strip;
  logic                   accept;
  logic                   last_pixel;
  logic [STRIP_COUNT-1:0] strip_onehot;

  // A restart request owns the cycle, so no pixel may slip in alongside it.
  assign pixel_ready_o = (state == LOAD) && !frame_start_i;
  assign accept        = pixel_ready_o && pixel_valid_i;
  assign last_pixel    = (addr == LAST_ADDR) && (strip == LAST_STRIP);

  always_comb begin
    strip_onehot = '0;
    for (int i = 0; i < STRIP_COUNT; i++) begin
      strip_onehot[i] = (strip == 3'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      addr          <= '0;
      strip         <= '0;
      pixel_r_o     <= '0;
      pixel_g_o     <= '0;
      pixel_b_o     <= '0;
      led_address_o <= '0;
      strip_we_o    <= '0;
      frame_busy_o  <= 1'b0;
      frame_done_o  <= 1'b0;
      abort_o       <= 1'b0;
    end else begin
      strip_we_o   <= '0;
      frame_done_o <= 1'b0;

      if (accept) begin
        pixel_r_o     <= pixel_r_i;
        pixel_g_o     <= pixel_g_i;
        pixel_b_o     <= pixel_b_i;
        led_address_o <= addr;
        strip_we_o    <= strip_onehot;
      end

      // Setting wins over a simultaneous clear.
      if (state == LOAD && frame_start_i) begin
        abort_o <= 1'b1;
      end else if (clear_abort_i) begin
        abort_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_start_i) begin
            state        <= LOAD;
            frame_busy_o <= 1'b1;
            addr         <= '0;
            strip        <= '0;
          end
        end
        LOAD: begin
          if (frame_start_i) begin
            addr  <= '0;
            strip <= '0;
          end else if (accept) begin
            if (last_pixel) begin
              state        <= DONE;
              frame_busy_o <= 1'b0;
              frame_done_o <= 1'b1;
              addr         <= '0;
              strip        <= '0;
            end else if (addr == LAST_ADDR) begin
              addr  <= '0;
              strip <= strip + 3'd1;
            end else begin
              addr <= addr + 9'd1;
            end
          end
        end
        DONE: begin
          if (frame_start_i) begin
            state        <= LOAD;
            frame_busy_o <= 1'b1;
            addr         <= '0;
            strip        <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          frame_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/strip_write_scheduler.md
STRIP_WRITE_SCHEDULER -- requirements
Module: strip_write_scheduler

Interface
REQ-001 The module SHALL have the parameter LED_COUNT, default 240, giving LEDs per strip (legal range 1..512).
REQ-002 The module SHALL have the parameter STRIP_COUNT, default 4, giving the number of strips served (legal range 1..8).
REQ-003 Port clk_i, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port frame_start_i, input, 1 bit: single-cycle pulse that begins loading a frame.
REQ-006 Port pixel_valid_i, input, 1 bit: the source presents a pixel.
REQ-007 Ports pixel_r_i, pixel_g_i, pixel_b_i, input, 8 bits each: the colour of the presented pixel.
REQ-008 Port pixel_ready_o, output, 1 bit: the scheduler accepts a pixel this cycle.
REQ-009 Ports pixel_r_o, pixel_g_o, pixel_b_o, output, 8 bits each: registered colour routed to the strip RAM write ports.
REQ-010 Port led_address_o, output, 9 bits: registered write address within the selected strip.
REQ-011 Port strip_we_o, output, STRIP_COUNT bits: one-hot registered write strobe, one bit per strip.
REQ-012 Port frame_busy_o, output, 1 bit: the FSM is in the LOAD state.
REQ-013 Port frame_done_o, output, 1 bit: single-cycle pulse when a frame completes.
REQ-014 Port abort_o, output, 1 bit: sticky flag meaning a frame was restarted before completing.
REQ-015 Port clear_abort_i, input, 1 bit: clears abort_o.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD and DONE.
REQ-017 IDLE SHALL go to LOAD on frame_start_i; the address and strip counters SHALL be zeroed on that edge.
REQ-018 LOAD SHALL assert pixel_ready_o combinationally; IDLE and DONE SHALL hold pixel_ready_o low.
REQ-019 An accept SHALL occur when pixel_valid_i and pixel_ready_o are both high.
REQ-020 Each accept SHALL register the pixel colour, led_address_o = address counter, and strip_we_o = one-hot(strip counter), giving 1-cycle latency.
REQ-021 strip_we_o SHALL be all-zero in every cycle not following an accept.
REQ-022 Write order SHALL be strip-major: addresses 0..LED_COUNT-1 on strip 0, then on strip 1, and so on.
REQ-023 After an accept at address LED_COUNT-1, the address counter SHALL wrap to 0 and the strip counter SHALL increment.
REQ-024 An accept at address LED_COUNT-1 of strip STRIP_COUNT-1 SHALL be the last pixel, and LOAD SHALL go to DONE.
REQ-025 DONE SHALL last exactly one cycle, assert frame_done_o during it, and then go to IDLE.
REQ-026 frame_done_o SHALL coincide with the cycle in which the last strip_we_o is presented.
REQ-027 frame_start_i during LOAD SHALL restart the frame: both counters zeroed, abort_o set, and no pixel accepted that cycle (ready forced low).
REQ-028 frame_start_i during DONE SHALL be honoured: DONE goes to LOAD with the counters zeroed and abort_o left unchanged.
REQ-029 In IDLE, pixel_valid_i SHALL be ignored, including when it is simultaneous with frame_start_i.
REQ-030 clear_abort_i SHALL clear abort_o, except that a simultaneous abort condition SHALL win and abort_o is set.
REQ-031 Counters SHALL be 9-bit address and 3-bit strip; values at or beyond LED_COUNT or STRIP_COUNT SHALL never be produced.

Reset
REQ-032 While rst_n_i is low, the state SHALL be IDLE and the counters 0.
REQ-033 While rst_n_i is low, all outputs SHALL be 0: pixel_ready_o, pixel_r/g/b_o, led_address_o, strip_we_o, frame_busy_o, frame_done_o and abort_o.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no further strip_we_o.
REQ-035 After rst_n_i deasserts, the block SHALL need a new frame_start_i before accepting pixels.

Verification (LED_COUNT=4, STRIP_COUNT=2 unless noted)
REQ-036 Full frame: frame_start, then 8 back-to-back pixels 0x010203..0x080808 -> writes (strip0, addr 0..3), then (strip1, addr 0..3), each one cycle after accept; frame_done_o pulses with the 8th write; then IDLE.
REQ-037 Throttled source: pixel_valid_i toggles every other cycle -> still exactly 8 writes, in order, with no duplicate or missing addresses, and strip_we_o zero in gap cycles.
REQ-038 Mid-frame restart: frame_start after 5 accepts -> abort_o=1; next accept writes strip0 addr0; full 8 writes follow; clear_abort_i then drops abort_o to 0.
REQ-039 Idle and done behaviour: pixel_valid_i held high in IDLE -> pixel_ready_o=0 and strip_we_o=0; frame_start in the DONE cycle -> LOAD entered and abort_o stays 0.
REQ-040 Reset mid-frame: rst_n_i low after 3 accepts -> all outputs 0 immediately; after release, pixels are ignored until frame_start.
REQ-041 Boundary case, LED_COUNT=512 and STRIP_COUNT=1: 512 accepts -> addresses 0..511, strip_we_o=1'b1, and frame_done_o at address 511.
